// File: rtl/key_pkg.sv
// Shared defaults and per-channel action encoding for the push-button debouncer.
package key_pkg;

    localparam int KEY_NUM_KEYS_DEF = 2;
    localparam int KEY_CNT_W_DEF    = 20;
    localparam int KEY_DB_COUNT_DEF = 1000000;

    typedef enum logic [1:0] {
        CH_HOLD   = 2'd0,
        CH_COUNT  = 2'd1,
        CH_ACCEPT = 2'd2
    } ch_state_e;

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, stability counter, accepted level.
// Rising-edge pulse register exists only when KEY_DEBOUNCE_RISE_EN is defined.
//
// state     | meaning
// CH_HOLD   | sample matches accepted level, counter held at 0
// CH_COUNT  | sample differs, counter still below terminal count
// CH_ACCEPT | sample differed for DB_COUNT cycles, level loads the sample
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int CNT_W    = KEY_CNT_W_DEF,
    parameter int DB_COUNT = KEY_DB_COUNT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_lvl,
    output logic key_rise
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_COUNT - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_lvl;
    ch_state_e        w_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= key_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_state = CH_HOLD;
        if (r_sync2 != r_lvl) begin
            w_state = (r_cnt == CNT_MAX) ? CH_ACCEPT : CH_COUNT;
        end
    end

    // Counter only runs while the sample disagrees, so it can never pass CNT_MAX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_lvl <= 1'b0;
        end else begin
            case (w_state)
                CH_COUNT:  r_cnt <= r_cnt + CNT_W'(1);
                CH_ACCEPT: begin
                    r_cnt <= '0;
                    r_lvl <= r_sync2;
                end
                default:   r_cnt <= '0;
            endcase
        end
    end

    assign key_lvl = r_lvl;

`ifdef KEY_DEBOUNCE_RISE_EN
    logic r_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rise <= 1'b0;
        end else begin
            r_rise <= (w_state == CH_ACCEPT) && r_sync2;
        end
    end

    assign key_rise = r_rise;
`else
    assign key_rise = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Multi-key push-button debouncer; one independent key_debounce_ch per key.
// Define KEY_DEBOUNCE_RISE_EN to enable the key_rise edge pulses.
module key_debounce
    import key_pkg::*;
#(
    parameter int NUM_KEYS = KEY_NUM_KEYS_DEF,
    parameter int CNT_W    = KEY_CNT_W_DEF,
    parameter int DB_COUNT = KEY_DB_COUNT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_lvl,
    output logic [NUM_KEYS-1:0] key_rise
);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .CNT_W    (CNT_W),
            .DB_COUNT (DB_COUNT)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .key_raw  (key_raw[g]),
            .key_lvl  (key_lvl[g]),
            .key_rise (key_rise[g])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with DB_COUNT=4, CNT_W=3, NUM_KEYS=2.
module tb_key_debounce;

    localparam int NK = 2;
    localparam int CW = 3;
    localparam int DB = 4;
`ifdef KEY_DEBOUNCE_RISE_EN
    localparam bit RISE_EN = 1'b1;
`else
    localparam bit RISE_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NK-1:0] key_raw = '0;
    logic [NK-1:0] key_lvl;
    logic [NK-1:0] key_rise;

    key_debounce #(
        .NUM_KEYS (NK),
        .CNT_W    (CW),
        .DB_COUNT (DB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .key_raw  (key_raw),
        .key_lvl  (key_lvl),
        .key_rise (key_rise)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NK-1:0] lvl;
        logic [NK-1:0] rise;
        string         tag;
    } exp_t;

    exp_t          sb[$];
    logic [NK-1:0] hist[DB+2];
    logic [NK-1:0] m_lvl = '0;
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: a level flips once the last DB raw samples (two edges back
    // through the synchronizer) all disagree with it.
    task automatic step(input logic [NK-1:0] raw, input logic rst, input string tag);
        exp_t          e;
        logic [NK-1:0] m_rise;
        bit            all_diff;
        @(negedge clk);
        key_raw = raw;
        reset   = rst;
        m_rise  = '0;
        if (rst) begin
            for (int j = 0; j < DB + 2; j++) hist[j] = '0;
            m_lvl = '0;
        end else begin
            for (int j = DB + 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = raw;
            for (int k = 0; k < NK; k++) begin
                all_diff = 1'b1;
                for (int j = 2; j <= DB + 1; j++) begin
                    if (hist[j][k] == m_lvl[k]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_lvl[k] = ~m_lvl[k];
                    if (m_lvl[k]) m_rise[k] = RISE_EN;
                end
            end
        end
        e.lvl  = m_lvl;
        e.rise = m_rise;
        e.tag  = tag;
        sb.push_back(e);
        if (rst) begin
            #1;
            check({tag, "_async_lvl"}, 32'(key_lvl), 32'd0);
            check({tag, "_async_rise"}, 32'(key_rise), 32'd0);
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, "_lvl"}, 32'(key_lvl), 32'(e.lvl));
        check({e.tag, "_rise"}, 32'(key_rise), 32'(e.rise));
    endtask

    task automatic hold(input logic [NK-1:0] raw, input int n, input string tag);
        for (int i = 0; i < n; i++) step(raw, 1'b0, tag);
    endtask

    initial begin
        for (int j = 0; j < DB + 2; j++) hist[j] = '0;

        for (int i = 0; i < 3; i++) step(2'b11, 1'b1, "rst");
        hold(2'b11, 8, "rel_rst");
        hold(2'b00, 8, "fall");

        hold(2'b01, 8, "press0");

        step(2'b11, 1'b0, "bounce"); step(2'b11, 1'b0, "bounce"); step(2'b11, 1'b0, "bounce");
        step(2'b01, 1'b0, "bounce");
        step(2'b11, 1'b0, "bounce"); step(2'b11, 1'b0, "bounce"); step(2'b11, 1'b0, "bounce");
        hold(2'b01, 8, "bounce");

        hold(2'b00, 8, "rel0");

        hold(2'b11, 8, "simul");
        hold(2'b00, 8, "simul_off");

        hold(2'b01, 3, "midcnt");
        step(2'b01, 1'b1, "midrst");
        hold(2'b01, 8, "recount");

        step(2'b01, 1'b1, "lvl_rst");
        hold(2'b00, 3, "post_rst");

        for (int i = 0; i < 60; i++) begin
            step(NK'($urandom_range(0, 3)), 1'b0, "rand");
        end
        hold(2'b10, 8, "final");

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL expose parameter NUM_KEYS, default 2, number of independent push-button channels.
REQ-002 The block SHALL expose parameter CNT_W, default 20, stability counter width in bits.
REQ-003 The block SHALL expose parameter DB_COUNT, default 1000000, consecutive stable cycles required to accept a new level (20 ms at 50 MHz).
REQ-004 The block SHALL have port clk, input, 1, the single system clock; all state SHALL be clocked on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port key_raw, input, NUM_KEYS, raw asynchronous push-button levels (1 = pressed).
REQ-007 The block SHALL have port key_lvl, output, NUM_KEYS, debounced registered level per key, feeding the serial-entry shift stage's ln0/ln1 inputs.
REQ-008 The block SHALL have port key_rise, output, NUM_KEYS, one-cycle registered pulse on each accepted 0->1 transition of key_lvl.

Function
REQ-009 Each channel SHALL pass key_raw[i] through a two-flop synchronizer; the second flop output is the sample s[i].
REQ-010 Each channel SHALL hold a CNT_W-bit counter cnt[i] and accepted level key_lvl[i].
REQ-011 Each cycle, when s[i] == key_lvl[i], cnt[i] SHALL load 0.
REQ-012 Each cycle, when s[i] != key_lvl[i] and cnt[i] < DB_COUNT-1, cnt[i] SHALL increment by 1.
REQ-013 Each cycle, when s[i] != key_lvl[i] and cnt[i] == DB_COUNT-1, key_lvl[i] SHALL load s[i] and cnt[i] SHALL load 0.
REQ-014 Latency: a raw change stable from before edge k SHALL appear on key_lvl at edge k+1+DB_COUNT.
REQ-015 Any excursion of s[i] lasting fewer than DB_COUNT cycles SHALL leave key_lvl[i] unchanged and reset cnt[i] to 0 on return.
REQ-016 key_rise[i] SHALL be 1 for exactly the one cycle following the edge at which key_lvl[i] goes 0->1, else 0; a 1->0 acceptance SHALL NOT pulse.
REQ-017 Channels SHALL be fully independent; simultaneous transitions on several keys SHALL each be accepted at their own REQ-014 edge.
REQ-018 DB_COUNT SHALL be >= 1 and <= 2**CNT_W; DB_COUNT = 1 SHALL accept s[i] one cycle after it differs.
REQ-019 cnt[i] SHALL never exceed DB_COUNT-1 and SHALL never wrap.

Reset
REQ-020 Asserting reset SHALL immediately clear synchronizer flops, cnt, key_lvl and key_rise to 0, including mid-count.
REQ-021 After reset deassertion with key_raw held high, key_lvl SHALL rise per REQ-014 timing, producing one key_rise pulse.

Configuration
REQ-022 Macro KEY_DEBOUNCE_RISE_EN SHALL control the edge-pulse feature.
REQ-023 With KEY_DEBOUNCE_RISE_EN defined, key_rise SHALL behave per REQ-016.
REQ-024 Without KEY_DEBOUNCE_RISE_EN, key_rise SHALL be constant 0 and its register SHALL be omitted; key_lvl behaviour SHALL be unchanged.

Structure
REQ-025 A shared package key_pkg SHALL hold the default constants for NUM_KEYS, CNT_W and DB_COUNT, and the channel state encoding.
REQ-026 Per-key logic SHALL live in sub-module key_debounce_ch, instantiated NUM_KEYS times by key_debounce.

Verification (DB_COUNT=4, CNT_W=3, NUM_KEYS=2)
REQ-027 Reset: reset=1 with key_raw=2'b11 -> key_lvl=0, key_rise=0 throughout; release -> key_lvl=2'b11 at edge 5 after release, key_rise=2'b11 for one cycle.
REQ-028 Clean press: key_raw[0] 0->1 before edge 0, held -> key_lvl[0]=1 after edge 5, key_rise[0]=1 only in cycle after edge 5.
REQ-029 Bounce: key_raw[1] high 3 cycles, low 1, high 3, low -> key_lvl[1] stays 0, key_rise[1] never asserts.
REQ-030 Release: key_lvl[0]=1, key_raw[0] 1->0 held -> key_lvl[0]=0 after 5 edges, key_rise[0] stays 0.
REQ-031 Reset mid-count: key_raw[0] high, reset pulsed at edge 3 -> key_lvl[0]=0, recount starts; key_lvl[0]=1 at edge 5 after release.
REQ-032 Simultaneous: both keys 0->1 same cycle -> both key_lvl bits and both key_rise bits assert on the same edge.
